// File: rtl/ysyx_23060201_ifu_fetch_pkg.sv
// Shared definitions for the ysyx_23060201 instruction fetch unit.
//   fetch_state_e    : fetch FSM states
//   RESP_OKAY        : read response code for a successful read
//   RESET_PC_DEFAULT : default PC loaded on reset
//   INST_BYTES       : bytes per instruction (sequential PC increment)
package ysyx_23060201_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_RESP    = 3'd2,
    S_OUT     = 3'd3,
    S_WAIT_WB = 3'd4
  } fetch_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          INST_BYTES       = 4;

endpackage

// File: rtl/ysyx_23060201_ifu_fetch_if.sv
// Bus bundle of the fetch unit: AR/R read channel to instruction SRAM,
// valid/ready instruction output to decode, commit/redirect from writeback,
// and the sticky fetch error flag.
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clock edge where both valid and ready are high; once valid is raised
// it and its payload stay stable until that transfer.
//
//   master : the fetch unit (drives araddr/arvalid/rready/out_*/fetch_err)
//   slave  : the surroundings (SRAM, decode, writeback)
interface ysyx_23060201_ifu_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_inst;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  wb_valid;
  logic                  jump_en;
  logic [ADDR_WIDTH-1:0] dnpc;
  logic                  fetch_err;

  modport master (
    output araddr, arvalid, rready, out_valid, out_inst, out_pc, fetch_err,
    input  arready, rdata, rresp, rvalid, out_ready, wb_valid, jump_en, dnpc
  );

  modport slave (
    input  araddr, arvalid, rready, out_valid, out_inst, out_pc, fetch_err,
    output arready, rdata, rresp, rvalid, out_ready, wb_valid, jump_en, dnpc
  );
endinterface

// File: rtl/ysyx_23060201_ifu_fetch.sv
// Multi-cycle instruction fetch unit. Owns the PC, issues one AR/R read at a
// time, hands the instruction to decode, and advances the PC only on commit
// from writeback, so exactly one instruction is in flight.
//
// Ports:
//   clk       : core clock
//   rst_n     : asynchronous active-low reset
//   bus       : fetch bundle (master side), see ysyx_23060201_ifu_fetch_if
//   dbg_state : current FSM state, for observation only
//
// Every output is decoded from registered state; no input reaches an output
// combinationally.
module ysyx_23060201_ifu_fetch
  import ysyx_23060201_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ysyx_23060201_ifu_fetch_if.master     bus,
  output fetch_state_e                  dbg_state
);

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] inst;
  logic                  fetch_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      inst      <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        // One idle cycle after reset so an arready already high at reset
        // release cannot complete a transfer.
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (bus.arready) state <= S_RESP;
        end

        // The instruction is delivered even on an error response; the error
        // is only recorded in the sticky flag.
        S_RESP: begin
          if (bus.rvalid) begin
            inst <= bus.rdata;
            if (bus.rresp != RESP_OKAY) fetch_err <= 1'b1;
            state <= S_OUT;
          end
        end

        S_OUT: begin
          if (bus.out_ready) state <= S_WAIT_WB;
        end

        // A misaligned redirect target is forced to word alignment and
        // flagged; the sequential increment wraps silently.
        S_WAIT_WB: begin
          if (bus.wb_valid) begin
            if (bus.jump_en) begin
              pc <= {bus.dnpc[ADDR_WIDTH-1:2], 2'b00};
              if (bus.dnpc[1:0] != 2'b00) fetch_err <= 1'b1;
            end else begin
              pc <= pc + ADDR_WIDTH'(INST_BYTES);
            end
            state <= S_REQ;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.araddr    = pc;
  assign bus.arvalid   = (state == S_REQ);
  assign bus.rready    = (state == S_RESP);
  assign bus.out_valid = (state == S_OUT);
  assign bus.out_inst  = inst;
  assign bus.out_pc    = pc;
  assign bus.fetch_err = fetch_err;
  assign dbg_state     = state;

endmodule

// File: tb/tb_ysyx_23060201_ifu_fetch.sv
// Bench for ysyx_23060201_ifu_fetch: directed scenarios followed by random
// handshakes, checked by a negedge monitor against a transaction-level model.
module tb_ysyx_23060201_ifu_fetch;
  import ysyx_23060201_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fetch_state_e dbg_state;

  ysyx_23060201_ifu_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ysyx_23060201_ifu_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [AW+DW-1:0] exp_q[$];   // {pc, inst} expected at decode, in order
  logic [AW+DW-1:0] exp_e;
  logic [AW-1:0] m_pc;          // architectural PC of the model
  logic          m_err;         // model of the sticky error flag
  bit            m_delivered;   // instruction accepted by decode, not yet committed
  int            ar_count, commit_count;
  int            ar_cyc[$];
  bit            prev_ar_hold, prev_out_hold;
  logic [AW-1:0] prev_araddr;
  logic [DW-1:0] prev_inst;

  // stimulus knobs
  int            p_ar, p_r, p_out, p_wb;
  bit            rand_data, rand_resp, rand_jump;
  logic [DW-1:0] fix_data;
  logic [1:0]    fix_resp;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout waiting for DUT (t=%0t)", name, $time);
  endtask

  // ---------------- monitor / reference model ----------------
  // Compares outputs against the model, then applies the handshakes that
  // will complete on the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc = RST_PC; m_err = 1'b0; m_delivered = 0;
      exp_q.delete(); ar_cyc.delete();
      ar_count = 0; commit_count = 0;
      prev_ar_hold = 0; prev_out_hold = 0;
      check("rst_arvalid", 64'(bus.arvalid), 64'(0));
      check("rst_rready", 64'(bus.rready), 64'(0));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_fetch_err", 64'(bus.fetch_err), 64'(0));
      check("rst_araddr", 64'(bus.araddr), 64'(RST_PC));
      check("rst_out_inst", 64'(bus.out_inst), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    end else begin
      check("out_pc", 64'(bus.out_pc), 64'(m_pc));
      check("araddr", 64'(bus.araddr), 64'(m_pc));
      check("fetch_err", 64'(bus.fetch_err), 64'(m_err));
      if (prev_ar_hold) begin
        check("ar_hold_valid", 64'(bus.arvalid), 64'(1));
        check("ar_hold_addr", 64'(bus.araddr), 64'(prev_araddr));
      end
      if (prev_out_hold) begin
        check("out_hold_valid", 64'(bus.out_valid), 64'(1));
        check("out_hold_inst", 64'(bus.out_inst), 64'(prev_inst));
      end
      if (bus.arvalid) check("no_dup_fetch", 64'(ar_count), 64'(commit_count));
      if (bus.rready)  check("r_after_ar", 64'(ar_count), 64'(commit_count + 1));

      if (bus.wb_valid && m_delivered) begin
        m_delivered = 0;
        commit_count++;
        if (bus.jump_en) begin
          m_pc = bus.dnpc & ~32'h3;
          if (bus.dnpc[1:0] != 2'b00) m_err = 1'b1;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
      if (bus.arvalid && bus.arready) begin
        ar_count++;
        ar_cyc.push_back(cyc);
      end
      if (bus.rvalid && bus.rready) begin
        exp_q.push_back({m_pc, bus.rdata});
        if (bus.rresp != 2'b00) m_err = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL out_unexpected: got inst %h with nothing expected", bus.out_inst);
        end else begin
          exp_e = exp_q.pop_front();
          check("out_inst", 64'(bus.out_inst), 64'(exp_e[DW-1:0]));
          check("out_pc_tag", 64'(bus.out_pc), 64'(exp_e[AW+DW-1:DW]));
        end
        m_delivered = 1;
      end
      prev_ar_hold  = bus.arvalid && !bus.arready;
      prev_araddr   = bus.araddr;
      prev_out_hold = bus.out_valid && !bus.out_ready;
      prev_inst     = bus.out_inst;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = 2'b00;
    bus.out_ready = 0; bus.wb_valid = 0; bus.jump_en = 0; bus.dnpc = '0;
  endtask

  task automatic set_knobs(int pa, int pr, int po, int pw);
    p_ar = pa; p_r = pr; p_out = po; p_wb = pw;
  endtask

  task automatic step();
    tick();
    bus.arready   = ($urandom_range(99) < 32'(p_ar));
    bus.rvalid    = ($urandom_range(99) < 32'(p_r));
    bus.out_ready = ($urandom_range(99) < 32'(p_out));
    bus.wb_valid  = ($urandom_range(99) < 32'(p_wb));
    bus.rdata     = rand_data ? DW'($urandom) : fix_data;
    bus.rresp     = rand_resp ? (($urandom_range(9) == 0) ? 2'b10 : 2'b00) : fix_resp;
    if (rand_jump) begin
      bus.jump_en = ($urandom_range(3) == 0);
      bus.dnpc    = AW'($urandom);
      if ($urandom_range(7) != 0) bus.dnpc[1:0] = 2'b00;
    end
  endtask

  task automatic run_commits(int n, string name);
    int target;
    int guard;
    target = commit_count + n;
    guard = 0;
    while (commit_count < target && guard < 3000) begin
      step();
      guard++;
    end
    if (commit_count < target) fail_timeout(name);
  endtask

  task automatic wait_arvalid(string name);
    int guard;
    guard = 0;
    while (!bus.arvalid && guard < 50) begin tick(); guard++; end
    if (!bus.arvalid) fail_timeout(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    set_knobs(100, 100, 100, 100);
    rand_data = 0; rand_resp = 0; rand_jump = 0;
    fix_data = 32'h0010_0093; fix_resp = 2'b00;
    repeat (3) tick();

    // Straight-line fetch, every handshake on first opportunity; arready is
    // already high at reset release.
    bus.arready = 1; bus.rvalid = 1; bus.rdata = fix_data;
    bus.out_ready = 1; bus.wb_valid = 1;
    begin
      int rel_cyc;
      rst_n = 1'b1;
      rel_cyc = cyc;
      check("release_idle_arvalid", 64'(bus.arvalid), 64'(0));
      run_commits(2, "seq_commit");
      if (ar_cyc.size() >= 2) begin
        check("first_ar_cycle", 64'(ar_cyc[0]), 64'(rel_cyc + 1));
        check("ar_spacing", 64'(ar_cyc[1] - ar_cyc[0]), 64'(4));
      end else fail_timeout("ar_cycles");
    end

    // Backpressure with stray inputs in the wrong states.
    drive_idle();
    wait_arvalid("bp_arvalid");
    bus.wb_valid = 1; bus.jump_en = 1; bus.dnpc = 32'h0000_1234; bus.rvalid = 1;
    tick(); bus.wb_valid = 0; bus.jump_en = 0; bus.rvalid = 0;
    repeat (2) tick();
    bus.arready = 1; tick(); bus.arready = 0;
    repeat (2) tick();
    bus.rvalid = 1; bus.rdata = 32'h1234_5678; tick(); bus.rvalid = 0;
    bus.wb_valid = 1; bus.jump_en = 1; tick(); bus.wb_valid = 0; bus.jump_en = 0;
    repeat (4) tick();
    bus.out_ready = 1; tick(); bus.out_ready = 0;
    repeat (2) tick();
    bus.wb_valid = 1; tick(); bus.wb_valid = 0;
    tick();
    check("bp_pc_after", 64'(bus.out_pc), 64'(32'h8000_000C));

    // Redirect, aligned then misaligned.
    set_knobs(100, 100, 100, 100);
    bus.jump_en = 1; bus.dnpc = 32'h8000_0100;
    run_commits(1, "jump_aligned");
    check("jump_aligned_addr", 64'(bus.araddr), 64'(32'h8000_0100));
    bus.dnpc = 32'h8000_0102;
    run_commits(1, "jump_misaligned");
    check("jump_misaligned_addr", 64'(bus.araddr), 64'(32'h8000_0100));
    check("jump_misaligned_err", 64'(bus.fetch_err), 64'(1));

    // Wrap of the sequential increment.
    bus.dnpc = 32'hFFFF_FFFC;
    run_commits(1, "jump_top");
    bus.jump_en = 0;
    run_commits(1, "wrap");
    check("wrap_addr", 64'(bus.araddr), 64'(0));

    // Reset while waiting for read data, then a stale rvalid after release.
    set_knobs(100, 0, 100, 100);
    begin
      int guard;
      guard = 0;
      while (!bus.rready && guard < 50) begin step(); guard++; end
      if (!bus.rready) fail_timeout("reach_resp");
    end
    #2 rst_n = 1'b0;
    #1 check("async_rst_state", 64'(dbg_state), 64'(S_IDLE));
    check("async_rst_pc", 64'(bus.out_pc), 64'(RST_PC));
    drive_idle();
    repeat (2) tick();
    rst_n = 1'b1;
    bus.rvalid = 1; bus.rdata = 32'hDEAD_BEEF;
    tick();
    check("rearm_arvalid", 64'(bus.arvalid), 64'(1));
    check("stale_not_captured", 64'(bus.out_inst), 64'(0));
    tick();
    bus.rvalid = 0;

    // Error response: instruction still delivered, flag sticks.
    set_knobs(100, 100, 100, 100);
    fix_data = 32'h0000_0013; fix_resp = 2'b10;
    run_commits(1, "err_resp");
    fix_resp = 2'b00;
    run_commits(3, "after_err");
    check("err_sticky", 64'(bus.fetch_err), 64'(1));

    // Random handshakes, data, responses and redirects.
    set_knobs(60, 50, 55, 40);
    rand_data = 1; rand_resp = 1; rand_jump = 1;
    run_commits(300, "random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
